// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Contents: key-schedule FSM state type, round-constant table, round count
// and a bounded round-constant lookup helper.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_EXP  = 2'd3
  } ks_state_e;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for a given round index; out-of-table indices give zero.
  function automatic logic [7:0] rcon_f(input logic [3:0] idx);
    logic [7:0] r;
    if (idx <= 4'd9) begin
      r = RCON[idx];
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Round-key handoff channel (valid/ready).
// master: key-schedule side (drives rk_valid, rk, rk_idx; receives rk_ready)
// slave : consumer side (round-key store or cipher core)
interface aes_key_sched_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  modport master (output rk_valid, output rk, output rk_idx, input rk_ready);
  modport slave  (input rk_valid, input rk, input rk_idx, output rk_ready);
endinterface

// File: rtl/aes_sbox.sv
// Four parallel AES forward S-boxes, purely combinational.
// Ports: din  - 32-bit word, one byte per S-box
//        dout - substituted word, byte positions preserved
module aes_sbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset (255-b)*8, and 255-b is just ~b.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  assign dout = {sub_byte(din[31:24]), sub_byte(din[23:16]),
                 sub_byte(din[15:8]),  sub_byte(din[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key-schedule controller. Expands a 128-bit key into 11 round keys,
// one S-box pass (SubWord(RotWord(w3))) per round, and hands each round key
// out over a valid/ready channel.
// Ports: clk, rst_n (async active-low), start/key (expansion request),
//        rk_if (round-key channel, master side), busy (not idle),
//        done (one-cycle pulse after round key NR is taken).
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    key,
  aes_key_sched_if.master rk_if,
  output logic            busy,
  output logic            done
);

  if (NR != AES128_NR) begin : g_bad_nr
    $error("aes_key_sched supports only NR=10 (AES-128)");
  end

  ks_state_e   state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [31:0] temp_q, temp_d;
  logic [3:0]  idx_q, idx_d;
  logic        rk_valid_q, rk_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] rot_w3, sbox_out;
  logic [31:0] w0_nx, w1_nx, w2_nx, w3_nx;

  assign rot_w3 = {w3_q[23:0], w3_q[31:24]};

  aes_sbox u_sbox (
    .din  (rot_w3),
    .dout (sbox_out)
  );

  // Next round's words: each word chains off the freshly computed one before it.
  assign w0_nx = w0_q ^ temp_q;
  assign w1_nx = w1_q ^ w0_nx;
  assign w2_nx = w2_q ^ w1_nx;
  assign w3_nx = w3_q ^ w2_nx;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    temp_d  = temp_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w0_d    = key[127:96];
          w1_d    = key[95:64];
          w2_d    = key[63:32];
          w3_d    = key[31:0];
          idx_d   = 4'd0;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (rk_if.rk_ready) begin
          if (idx_q == 4'(NR)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SUB;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_SUB: begin
        temp_d  = sbox_out ^ {rcon_f(idx_q), 24'h000000};
        state_d = ST_EXP;
      end
      ST_EXP: begin
        w0_d    = w0_nx;
        w1_d    = w1_nx;
        w2_d    = w2_nx;
        w3_d    = w3_nx;
        idx_d   = idx_q + 4'd1;
        state_d = ST_EMIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are derived from the next state so they come straight off flops.
    rk_valid_d = (state_d == ST_EMIT);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, key words and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      w0_q       <= 32'h0;
      w1_q       <= 32'h0;
      w2_q       <= 32'h0;
      w3_q       <= 32'h0;
      temp_q     <= 32'h0;
      idx_q      <= 4'd0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      temp_q     <= temp_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_if.rk_valid = rk_valid_q;
  assign rk_if.rk       = {w0_q, w1_q, w2_q, w3_q};
  assign rk_if.rk_idx   = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 expansion, backpressure,
// ignored start, reset mid-expansion and back-to-back starts.
module tb_aes_key_sched;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = 128'h0;
  logic         busy, done;

  aes_key_sched_if rk_if ();

  aes_key_sched #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .rk_if (rk_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;

  logic [127:0] exp_rk [11];
  bit           exp_known [11];
  int           acc_cnt [11];
  int           acc_cyc [11];
  bit           rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_fips();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) exp_known[i] = 1'b1;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 11; i++) exp_known[i] = 1'b0;
    exp_rk[0]     = KEY_SEQ;
    exp_known[0]  = 1'b1;
    exp_rk[10]    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    exp_known[10] = 1'b1;
  endtask

  // Cycle counter; cycle 0 is the cycle in which start is presented.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random ready driver for the backpressure run.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rk_if.rk_ready = ($urandom_range(0, 99) < 30);
  end

  // Handshake monitor: value per index, acceptance count/cycle, hold stability.
  initial begin : monitor
    bit           hold_pend;
    logic [127:0] hold_rk;
    logic [3:0]   hold_idx;
    int           idx;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend) begin
          check_eq("hold_rk", rk_if.rk, hold_rk);
          check_eq("hold_idx", 128'(rk_if.rk_idx), 128'(hold_idx));
        end
        if (rk_if.rk_valid && rk_if.rk_ready) begin
          idx = int'(rk_if.rk_idx);
          if (idx <= 10) begin
            acc_cnt[idx]++;
            acc_cyc[idx] = cyc - start_cyc;
            if (exp_known[idx]) check_eq($sformatf("rk[%0d]", idx), rk_if.rk, exp_rk[idx]);
          end else begin
            check_eq("rk_idx_range", 128'(rk_if.rk_idx), 128'd10);
          end
        end
        hold_pend = rk_if.rk_valid && !rk_if.rk_ready;
        hold_rk   = rk_if.rk;
        hold_idx  = rk_if.rk_idx;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // Present start for cycle 0; returns 1 time unit into cycle 1.
  task automatic kick(input logic [127:0] k, input bit hold);
    @(posedge clk);
    #1;
    key       = k;
    start     = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      acc_cnt[i] = 0;
      acc_cyc[i] = -1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      key   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    end
  endtask

  task automatic wait_done(input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        rel = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rk_valid"}, 128'(rk_if.rk_valid), 128'd0);
    check_eq({pfx, "_busy"},     128'(busy),           128'd0);
    check_eq({pfx, "_done"},     128'(done),           128'd0);
    check_eq({pfx, "_rk"},       rk_if.rk,             128'h0);
    check_eq({pfx, "_rk_idx"},   128'(rk_if.rk_idx),   128'd0);
  endtask

  initial begin
    int  rel;
    bit  found;
    rk_if.rk_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      acc_cnt[i]   = 0;
      acc_cyc[i]   = -1;
      exp_known[i] = 1'b0;
    end

    // Reset state.
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FIPS-197 vector, ready tied high.
    load_fips();
    kick(KEY_FIPS, 1'b0);
    wait_done(100, rel);
    check_eq("fips_done_cyc", 128'(rel), 128'd32);
    check_eq("fips_busy_at_done", 128'(busy), 128'd0);
    check_eq("fips_idx0_cyc", 128'(acc_cyc[0]), 128'd1);
    check_eq("fips_idx1_cyc", 128'(acc_cyc[1]), 128'd4);
    check_eq("fips_idx10_cyc", 128'(acc_cyc[10]), 128'd31);
    @(negedge clk);
    check_eq("done_pulse_len", 128'(done), 128'd0);

    // Backpressure: ready random with about 30% duty.
    rand_ready = 1'b1;
    kick(KEY_FIPS, 1'b0);
    wait_done(3000, rel);
    check_eq("bp_done_seen", 128'(rel > 32), 128'd1);
    for (int i = 0; i < 11; i++) check_eq($sformatf("bp_cnt[%0d]", i), 128'(acc_cnt[i]), 128'd1);
    rand_ready = 1'b0;
    @(posedge clk);
    #1 rk_if.rk_ready = 1'b1;

    // start during an expansion is ignored.
    kick(KEY_FIPS, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    key   = KEY_SEQ;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(100, rel);
    check_eq("ign_done_cyc", 128'(rel), 128'd32);
    check_eq("ign_idx10_cyc", 128'(acc_cyc[10]), 128'd31);
    for (int i = 0; i < 11; i++) check_eq($sformatf("ign_cnt[%0d]", i), 128'(acc_cnt[i]), 128'd1);

    // Reset while round key 4 is on the channel, then restart with another key.
    kick(KEY_FIPS, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rk_if.rk_valid && rk_if.rk_idx == 4'd4) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_reach_idx4", 128'(found), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_seq();
    kick(KEY_SEQ, 1'b0);
    wait_done(100, rel);
    check_eq("seq_done_cyc", 128'(rel), 128'd32);
    check_eq("seq_idx10_cnt", 128'(acc_cnt[10]), 128'd1);
    check_eq("seq_idx10_cyc", 128'(acc_cyc[10]), 128'd31);

    // start held high: next expansion begins on the done cycle.
    load_fips();
    kick(KEY_FIPS, 1'b1);
    wait_done(100, rel);
    check_eq("b2b_done1_cyc", 128'(rel), 128'd32);
    check_eq("b2b_busy_at_done", 128'(busy), 128'd0);
    @(negedge clk);
    check_eq("b2b_valid_next", 128'(rk_if.rk_valid), 128'd1);
    check_eq("b2b_idx_next", 128'(rk_if.rk_idx), 128'd0);
    check_eq("b2b_rk_next", rk_if.rk, KEY_FIPS);
    check_eq("b2b_busy_next", 128'(busy), 128'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(100, rel);
    check_eq("b2b_done2_cyc", 128'(rel), 128'd64);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

AES-128 key-schedule controller that expands a 128-bit cipher key into the 11 round keys for the AES round datapath. It drives a single instance of the existing 32-bit `aes_sbox` through a state machine to compute SubWord(RotWord(w3)) once per round. Round keys are handed one at a time to the round-key store or cipher core over a valid/ready handshake. It sits between the key register bank and the AES round engine.

## Interface

Parameters:
- `NR`, default 10: number of expansion rounds. Only 10 (AES-128) is supported; any other value is a elaboration error.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: begin expansion of `key`; sampled only in IDLE.
- `key`, in, 128: cipher key; bits [127:96] are w0. Sampled on an accepted `start`.
- `rk_valid`, out, 1: `rk` and `rk_idx` hold a valid round key.
- `rk_ready`, in, 1: consumer accepts the round key while `rk_valid`=1.
- `rk`, out, 128: current round key, ordered {w0,w1,w2,w3} with w0 in bits [127:96].
- `rk_idx`, out, 4: index of the round key, 0..10.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after round key 10 is accepted.

## Operation

- The FSM has four states: IDLE, EMIT, SUB, EXP.
- **IDLE**
  - When `start`=1: latch `key` into w0..w3, clear `rk_idx`, go to EMIT.
  - Otherwise stay in IDLE.
- **EMIT**
  - `rk_valid`=1; `rk` = {w0,w1,w2,w3}.
  - When `rk_ready`=1 and `rk_idx`=NR: go to IDLE and assert `done` for one cycle in the next cycle.
  - When `rk_ready`=1 and `rk_idx`<NR: go to SUB.
  - When `rk_ready`=0: stay in EMIT with `rk` and `rk_idx` held stable.
- **SUB**
  - The sbox input is RotWord(w3) = {w3[23:0], w3[31:24]}.
  - Register `temp` <= sbox_out ^ {RCON[rk_idx], 24'h0}.
  - Go to EXP.
- **EXP**
  - w0' = w0^temp
  - w1' = w1^w0'
  - w2' = w2^w1'
  - w3' = w3^w2'
  - Register all four words, increment `rk_idx`, go to EMIT.
- RCON for `rk_idx` 0..9: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- All XORs are 32-bit, with no carries. `rk_idx` never exceeds 10.
- `start` in any state other than IDLE is ignored. In-flight expansion is never restarted.
- Changes on `key` after acceptance have no effect.
- Reset asserted mid-expansion returns the block to IDLE immediately. No `done` is produced and the partial key state is discarded.

## Timing

- Reset values:
  - state = IDLE
  - `rk_valid`=0, `busy`=0, `done`=0
  - `rk`=0, `rk_idx`=0, `temp`=0
- With `start` at cycle 0 and `rk_ready` tied high:
  - `rk_valid` rises at cycle 1 with idx 0.
  - Round key r is valid at cycle 1+3r.
  - Round key 10 is valid at cycle 31.
  - `done`=1 at cycle 32, and `busy` falls the same cycle.
- Throughput is 3 cycles per round key with no backpressure. Each cycle of `rk_ready`=0 in EMIT adds exactly one cycle.
- A handshake happens only on a cycle where `rk_valid`=1 and `rk_ready`=1. Each index is transferred exactly once.
- `rk_valid` is registered and does not depend combinationally on `rk_ready`.
- `start` in the same cycle as the `done` pulse (state already IDLE) is accepted.

## Structure

- Shared package `aes_pkg` holds:
  - the FSM state enum typedef;
  - the `RCON` constant array [0:9] of 8-bit values;
  - `AES128_NR` = 10.
- Sub-module: one instance of the existing `aes_sbox` (32-bit in/out, combinational), fed by RotWord(w3).
- No other sub-modules.

## Test plan

- **FIPS-197 vector.** Key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - idx 1 = a0fafe1788542cb123a339392a6c7605
  - idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 31
  - `done` at cycle 32
- **Backpressure.** Same key, `rk_ready` random with 30% duty:
  - each index 0..10 is accepted exactly once, with the same values as above;
  - `rk`/`rk_idx` stay stable while `rk_ready`=0.
- **Ignored start.** Pulse `start` with key 000102030405060708090a0b0c0d0e0f at cycle 5 of an expansion: outputs are unchanged from the uninterrupted FIPS run.
- **Reset mid-expansion.** Assert `rst_n`=0 while `rk_idx`=4:
  - all outputs go to their reset values asynchronously;
  - a restart with key 000102030405060708090a0b0c0d0e0f yields idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **Back-to-back starts.** `start` held high continuously: a new expansion begins the cycle `done` pulses, `rk_valid` rises the following cycle, and idx restarts at 0.
